// File: rtl/priority_encoder_8to3_reg_if.sv
// rtl/priority_encoder_8to3_reg_if.sv - request/code handshake bundle for the registered priority encoder
interface priority_encoder_8to3_reg_if;
  logic       en;
  logic [7:0] req;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic       multi;

  // Producer of requests and consumer of codes (testbench / upstream logic)
  modport master (
    output en,
    output req,
    output ack,
    input  code,
    input  valid,
    input  multi
  );

  // The encoder itself
  modport slave (
    input  en,
    input  req,
    input  ack,
    output code,
    output valid,
    output multi
  );
endinterface

// File: rtl/priority_encoder_8to3_reg.sv
// rtl/priority_encoder_8to3_reg.sv - synchronized, debounced 8-to-3 priority encoder with valid/ack output
module priority_encoder_8to3_reg #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  priority_encoder_8to3_reg_if.slave   bus
);

  // A count of 0..DEBOUNCE_CYCLES-1 fits in clog2(DEBOUNCE_CYCLES) bits; keep at least one bit.
  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       req_meta_q, req_meta_d;
  logic [7:0]       req_s_q, req_s_d;
  logic [7:0]       snap_q, snap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       code_q, code_d;
  logic             multi_q, multi_d;
  logic             valid_q, valid_d;

  // Index of the highest set bit; bit 7 wins over everything below it.
  function automatic logic [2:0] msb_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // True when two or more bits are set: clearing the lowest set bit leaves something behind.
  function automatic logic more_than_one(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

  // Two-stage synchronizer for the asynchronous request lines.
  always_comb begin
    req_meta_d = bus.req;
    req_s_d    = req_meta_q;
  end

  // Capture / debounce / handshake sequencing; outputs only change on issue and on ack.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    multi_d = multi_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (bus.en && (req_s_q != 8'd0)) begin
          snap_d  = req_s_q;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if ((req_s_q == 8'd0) || !bus.en) begin
          state_d = IDLE;
        end else if (req_s_q != snap_q) begin
          // Any movement on the lines restarts the full stability window.
          snap_d = req_s_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          code_d  = msb_index(snap_q);
          multi_d = more_than_one(snap_q);
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HOLD: begin
        // en is deliberately ignored here: an issued code stays pending until consumed.
        if (bus.ack) begin
          valid_d = 1'b0;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        // A key that is still held must be let go before another code can be issued.
        if (req_s_q == 8'd0) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared immediately by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_meta_q <= 8'd0;
      req_s_q    <= 8'd0;
      snap_q     <= 8'd0;
      cnt_q      <= '0;
      code_q     <= 3'd0;
      multi_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_meta_q <= req_meta_d;
      req_s_q    <= req_s_d;
      snap_q     <= snap_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      multi_q    <= multi_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.code  = code_q;
  assign bus.multi = multi_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_priority_encoder_8to3_reg.sv
// tb/tb_priority_encoder_8to3_reg.sv - directed self-checking bench for priority_encoder_8to3_reg
module tb_priority_encoder_8to3_reg;

  logic clk = 1'b0;
  logic rst_n;

  priority_encoder_8to3_reg_if bus ();

  priority_encoder_8to3_reg #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [2:0] code;
    logic       multi;
  } vec_t;

  vec_t vecs [9];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic count_valid(input int n, output int highs);
    highs = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.valid === 1'b1) highs++;
    end
  endtask

  // Called just after a negedge: the next posedge is edge k, valid must appear after edge k+6.
  task automatic press(input logic [7:0] r, input logic [2:0] c, input logic m, input string tag);
    int highs;
    bus.req = r;
    count_valid(6, highs);
    check({tag, "_no_early_valid"}, highs, 0);
    @(negedge clk);
    check({tag, "_valid"}, bus.valid, 1);
    check({tag, "_code"}, bus.code, c);
    check({tag, "_multi"}, bus.multi, m);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    int total;

    vecs[0] = '{8'h04, 3'd2, 1'b0};
    vecs[1] = '{8'h92, 3'd7, 1'b1};
    vecs[2] = '{8'h01, 3'd0, 1'b0};
    vecs[3] = '{8'h80, 3'd7, 1'b0};
    vecs[4] = '{8'h21, 3'd5, 1'b1};
    vecs[5] = '{8'h03, 3'd1, 1'b1};
    vecs[6] = '{8'h40, 3'd6, 1'b0};
    vecs[7] = '{8'hFF, 3'd7, 1'b1};
    vecs[8] = '{8'h18, 3'd4, 1'b1};

    // Reset with all requests active: outputs cleared with no clock and throughout.
    rst_n   = 1'b0;
    bus.en  = 1'b1;
    bus.ack = 1'b0;
    bus.req = 8'hFF;
    #1;
    check("reset_async_valid", bus.valid, 0);
    check("reset_async_code", bus.code, 0);
    check("reset_async_multi", bus.multi, 0);
    repeat (3) begin
      @(negedge clk);
      check("reset_valid", bus.valid, 0);
      check("reset_code", bus.code, 0);
      check("reset_multi", bus.multi, 0);
    end
    bus.req = 8'h00;
    rst_n   = 1'b1;
    repeat (3) @(negedge clk);

    // Table of single presses, each acked once and released.
    for (int i = 0; i < 9; i++) begin
      press(vecs[i].req, vecs[i].code, vecs[i].multi, $sformatf("vec%0d", i));
      bus.ack = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_ack_drop", i), bus.valid, 0);
      check($sformatf("vec%0d_code_kept", i), bus.code, vecs[i].code);
      bus.ack = 1'b0;
      bus.req = 8'h00;
      repeat (5) @(negedge clk);
    end

    // Ack tied high: one-cycle pulse, no re-issue while held, re-issue after release.
    bus.ack = 1'b1;
    press(8'h04, 3'd2, 1'b0, "tied_ack");
    @(negedge clk);
    check("tied_ack_pulse_width", bus.valid, 0);
    count_valid(20, highs);
    check("tied_ack_no_reissue", highs, 0);
    bus.req = 8'h00;
    repeat (5) @(negedge clk);
    press(8'h04, 3'd2, 1'b0, "tied_ack_second");
    @(negedge clk);
    check("tied_ack_second_drop", bus.valid, 0);
    bus.ack = 1'b0;
    bus.req = 8'h00;
    repeat (5) @(negedge clk);

    // Priority/multi held without ack for 20 cycles, then a single ack cycle.
    press(8'h92, 3'd7, 1'b1, "hold20");
    count_valid(20, highs);
    check("hold20_valid_held", highs, 20);
    check("hold20_code_frozen", bus.code, 7);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    check("hold20_ack_drop", bus.valid, 0);
    check("hold20_code_after", bus.code, 7);
    check("hold20_multi_after", bus.multi, 1);
    bus.req = 8'h00;
    repeat (5) @(negedge clk);

    // Bounce between 0x20 and 0x00 every 2 cycles, then settle on 0x20.
    total = 0;
    for (int p = 0; p < 3; p++) begin
      bus.req = 8'h20;
      count_valid(2, highs);
      total += highs;
      bus.req = 8'h00;
      count_valid(2, highs);
      total += highs;
    end
    check("bounce_no_valid", total, 0);
    press(8'h20, 3'd5, 1'b0, "bounce_settled");
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    bus.req = 8'h00;
    repeat (5) @(negedge clk);

    // Change 0x20 -> 0x21 mid-SETTLE: the count restarts from the new snapshot.
    bus.req = 8'h20;
    count_valid(3, highs);
    check("restart_pre_change", highs, 0);
    press(8'h21, 3'd5, 1'b1, "restart");
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    bus.req = 8'h00;
    repeat (5) @(negedge clk);

    // Disabled encoder ignores a held request.
    bus.en  = 1'b0;
    bus.req = 8'h08;
    count_valid(20, highs);
    check("disabled_no_valid", highs, 0);
    bus.req = 8'h00;
    repeat (3) @(negedge clk);
    bus.en = 1'b1;

    // Dropping en during HOLD does not cancel the pending code.
    press(8'h08, 3'd3, 1'b0, "en_drop");
    bus.en = 1'b0;
    count_valid(5, highs);
    check("en_drop_valid_held", highs, 5);
    check("en_drop_code", bus.code, 3);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    check("en_drop_ack", bus.valid, 0);
    bus.en  = 1'b1;
    bus.req = 8'h00;
    repeat (5) @(negedge clk);

    // Short press aborts back to IDLE without issuing.
    bus.req = 8'h01;
    repeat (3) @(negedge clk);
    bus.req = 8'h00;
    count_valid(12, highs);
    check("abort_no_valid", highs, 0);

    // Asynchronous reset in HOLD, then a fresh capture of the still-held key.
    press(8'h10, 3'd4, 1'b0, "pre_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_valid", bus.valid, 0);
    check("midreset_code", bus.code, 0);
    @(negedge clk);
    rst_n = 1'b1;
    press(8'h10, 3'd4, 1'b0, "post_reset");
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    check("post_reset_ack", bus.valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_encoder_8to3_reg.md
# priority_encoder_8to3_reg

Registered 8-to-3 priority encoder: the encode-side counterpart of the 3-to-8 structural decoder. It synchronizes and debounces eight request lines, such as switches or keypad rows, and converts the highest active line into a 3-bit code. The code is presented to downstream logic with a valid/ack handshake. One code is issued per press; the inputs must return to all-zero before the next code is issued.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a code is issued (legal range 1..255).
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  encoder enable; when 0, no new capture starts.
- req  input  8  asynchronous request lines; req[7] has highest priority.
- ack  input  1  consumer accepts the code; sampled only while valid=1.
- code  output  3  index of the highest set bit of the debounced snapshot (MSB first).
- valid  output  1  code/multi are valid and stable.
- multi  output  1  more than one req bit was set in the snapshot.

## Operation
- Synchronizer: two flops per req bit give req_s. Both stages reset to 0.
- Counter: DEBOUNCE_CYCLES is held in a counter of width clog2(DEBOUNCE_CYCLES), minimum 1 bit. There is also an 8-bit snapshot register.
- IDLE: valid=0. If en=1 and req_s!=0, then snapshot<=req_s, cnt<=0, and the FSM moves to SETTLE.
- SETTLE:
  - req_s==0 or en=0: go to IDLE.
  - req_s!=snapshot (and nonzero): snapshot<=req_s, cnt<=0, stay in SETTLE.
  - req_s==snapshot and cnt==DEBOUNCE_CYCLES-1: code<=highest set index of snapshot, multi<=(popcount(snapshot)>1), valid<=1, go to HOLD.
  - otherwise: cnt<=cnt+1.
- HOLD: valid, code and multi are frozen. On an edge with ack=1: valid<=0, go to RELEASE. en=0 does not cancel a pending code; valid stays high until ack.
- RELEASE: wait for req_s==0, then go to IDLE. A held key never re-issues a code.
- After valid falls, code and multi keep their last values until the next issue.
- ack while valid=0 is ignored. No state latches a pending ack.
- Priority: bit 7 beats bit 6 and so on down to bit 0, e.g. 8'b1001_0010 gives code=7.

## Timing
- Reset (async assert, sync release): code=3'd0, valid=0, multi=0, snapshot=0, cnt=0, sync flops=0, state=IDLE. Outputs clear immediately on rst_n falling, with no clock needed.
- Latency: req is stable and nonzero before edge k. req_s is valid after edge k+1, the SETTLE entry happens at edge k+2, and valid rises at edge k+2+DEBOUNCE_CYCLES. With the default of 4, that is edge k+6.
- Handshake: the transfer completes on the edge where valid=1 and ack=1. valid is low the cycle after that edge. The minimum valid pulse width is 1 cycle, which happens when ack is already high.
- Any change of req_s during SETTLE restarts the full DEBOUNCE_CYCLES count.
- Next issue: the earliest new SETTLE entry is 1 edge after RELEASE observes req_s==0 (through IDLE), plus the usual latency.
- Reset mid-operation: the FSM returns to IDLE. If req is still held after reset release, a fresh capture follows with normal latency.

## Test plan
- Reset: rst_n=0 for 3 cycles with req=8'hFF -> code=0, valid=0, multi=0 throughout. Also assert rst_n asynchronously between clock edges during HOLD -> valid drops at once.
- Single key: en=1, req=8'b0000_0100 held, ack tied 1 -> valid high for exactly 1 cycle at edge k+6, code=2, multi=0. No second pulse while req is held; a second pulse appears only after req goes to 0 and back to 8'b0000_0100.
- Priority/multi: req=8'b1001_0010, ack=0 -> code=7, multi=1, valid held for 20 cycles. Then ack=1 for 1 cycle -> valid=0 on the next edge, code stays 7.
- Bounce: toggle req between 8'h20 and 8'h00 every 2 cycles for 12 cycles, then hold 8'h20 -> no valid during bouncing; code=5 valid DEBOUNCE_CYCLES+2 edges after the last transition. Separately, switch 8'h20 to 8'h21 mid-SETTLE -> count restarts, and the issued code is 5 with multi=1.
- Enable: en=0 with req=8'h08 for 20 cycles -> valid stays 0. Separately, drop en during HOLD -> valid stays 1 until ack.
- Release abort: req=8'h01 for 3 cycles, then 8'h00 -> FSM returns to IDLE and valid never rises.
